// File: rtl/mic_buffer_ctrl.sv
// mic_buffer_ctrl: captures interleaved multi-channel FIR output samples into a
// double-banked (ping-pong) buffer memory. Each bank holds FRAME_SAMPLES rows of
// CHANNELS samples. When a bank fills, the write bank flips, buffer_selector names
// the finished bank and irq pulses. The host acknowledges with buf_ack. A bank
// that completes while the previous irq is still unacknowledged sets overrun.
//
// Build option MIC_BUFFER_SYNC_CHECK_EN:
//   defined   - capture starts only on a channel-0 sample, and every later sample
//               must carry the expected channel. A mismatch drops the partial bank,
//               sets sync_err and re-aligns on the next channel-0 sample.
//   undefined - every accepted sample is written at the address of its own channel
//               input, and sync_err is tied low.
//
// States:
//   state   | meaning
//   IDLE    | waiting for the first sample of a frame (channel 0 when checking)
//   FILL    | writing samples into the current bank
module mic_buffer_ctrl #(
  parameter int CHANNELS          = 8,
  parameter int CHANNELS_WIDTH    = 3,
  parameter int DATA_WIDTH        = 16,
  parameter int ADDR_WIDTH_BUFFER = 13,
  parameter int FRAME_SAMPLES     = 256
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         write_data,
  input  logic [CHANNELS_WIDTH-1:0]    channel,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         buf_ack,
  output logic                         mem_we,
  output logic [ADDR_WIDTH_BUFFER-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         buffer_selector,
  output logic                         irq,
  output logic                         overrun,
  output logic                         sync_err
);

  localparam int SIDX_W     = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
  localparam int BANK_WORDS = FRAME_SAMPLES * CHANNELS;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;

  logic                           r_wd_q;
  logic                           w_accept;

  logic [SIDX_W-1:0]              r_sidx;
  logic [SIDX_W-1:0]              w_sidx_next;
  logic                           r_wbank;
  logic                           w_wbank_next;

  logic                           w_do_write;
  logic                           w_complete;
  logic                           w_last_ch;
  logic                           w_last_sample;

  logic [ADDR_WIDTH_BUFFER-1:0]   w_bank_base;
  logic [ADDR_WIDTH_BUFFER-1:0]   w_row_base;
  logic [ADDR_WIDTH_BUFFER-1:0]   w_addr;

  logic                           r_mem_we;
  logic [ADDR_WIDTH_BUFFER-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]          r_mem_wdata;
  logic                           r_sel;
  logic                           r_irq;
  logic                           r_overrun;
  logic                           r_ack_pending;

`ifdef MIC_BUFFER_SYNC_CHECK_EN
  logic [CHANNELS_WIDTH-1:0]      r_exp;
  logic [CHANNELS_WIDTH-1:0]      w_exp_next;
  logic                           w_sync_fail;
  logic                           r_sync_err;
`endif

  // A sample is taken only on the rising edge of the valid level.
  assign w_accept      = write_data & ~r_wd_q;
  assign w_last_ch     = (channel == CHANNELS_WIDTH'(CHANNELS - 1));
  assign w_last_sample = (r_sidx == SIDX_W'(FRAME_SAMPLES - 1));

  // Write address: bank base + row base + channel offset.
  assign w_bank_base = r_wbank ? ADDR_WIDTH_BUFFER'(BANK_WORDS) : '0;
  assign w_row_base  = ADDR_WIDTH_BUFFER'(r_sidx) * ADDR_WIDTH_BUFFER'(CHANNELS);
  assign w_addr      = w_bank_base + w_row_base + ADDR_WIDTH_BUFFER'(channel);

  // Next-state, write decision and frame bookkeeping.
  always_comb begin
    w_state_next = r_state;
    w_do_write   = 1'b0;
    w_complete   = 1'b0;
    w_sidx_next  = r_sidx;
    w_wbank_next = r_wbank;
`ifdef MIC_BUFFER_SYNC_CHECK_EN
    w_exp_next   = r_exp;
    w_sync_fail  = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef MIC_BUFFER_SYNC_CHECK_EN
          // Align on channel 0; anything else is dropped silently.
          if (channel == '0) begin
            w_do_write   = 1'b1;
            w_state_next = ST_FILL;
          end
`else
          w_do_write   = 1'b1;
          w_state_next = ST_FILL;
`endif
        end
      end
      ST_FILL: begin
        if (w_accept) begin
`ifdef MIC_BUFFER_SYNC_CHECK_EN
          if (channel == r_exp) begin
            w_do_write = 1'b1;
          end else begin
            // Lost channel alignment: throw away the partial bank but keep the bank bit.
            w_sync_fail  = 1'b1;
            w_state_next = ST_IDLE;
            w_sidx_next  = '0;
            w_exp_next   = '0;
          end
`else
          w_do_write = 1'b1;
`endif
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_do_write) begin
      if (w_last_ch) begin
        if (w_last_sample) begin
          w_sidx_next  = '0;
          w_wbank_next = ~r_wbank;
          w_complete   = 1'b1;
        end else begin
          w_sidx_next = r_sidx + 1'b1;
        end
      end
`ifdef MIC_BUFFER_SYNC_CHECK_EN
      w_exp_next = w_last_ch ? '0 : channel + 1'b1;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Edge register, counters, memory write port and host status.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_wd_q        <= 1'b0;
      r_sidx        <= '0;
      r_wbank       <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_sel         <= 1'b0;
      r_irq         <= 1'b0;
      r_overrun     <= 1'b0;
      r_ack_pending <= 1'b0;
    end else begin
      r_wd_q   <= write_data;
      r_sidx   <= w_sidx_next;
      r_wbank  <= w_wbank_next;
      r_mem_we <= w_do_write;
      r_irq    <= w_complete;
      if (w_do_write) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= data_in;
      end
      if (w_complete) begin
        r_sel <= r_wbank;
        // An ack arriving in the same cycle as the completing write still clears the old irq.
        if (r_ack_pending && !buf_ack) begin
          r_overrun <= 1'b1;
        end
      end
      // The pending flag rises with irq; an ack during the irq cycle clears the new one.
      if (w_complete) begin
        r_ack_pending <= 1'b1;
      end else if (buf_ack) begin
        r_ack_pending <= 1'b0;
      end
    end
  end

`ifdef MIC_BUFFER_SYNC_CHECK_EN
  // Expected-channel tracker and sticky alignment error.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_exp      <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_exp <= w_exp_next;
      if (w_sync_fail) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  assign sync_err = r_sync_err;
`else
  assign sync_err = 1'b0;
`endif

  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign buffer_selector = r_sel;
  assign irq             = r_irq;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_mic_buffer_ctrl.sv
// Bench for mic_buffer_ctrl: a reference model pushes the expected memory writes
// to a queue as samples are driven; a monitor pops and compares each write.
module tb_mic_buffer_ctrl;

  localparam int CH    = 8;
  localparam int FS    = 256;
  localparam int BANK  = FS * CH;

  logic        clk;
  logic        resetn;
  logic        write_data;
  logic [2:0]  channel;
  logic [15:0] data_in;
  logic        buf_ack;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        buffer_selector;
  logic        irq;
  logic        overrun;
  logic        sync_err;

  mic_buffer_ctrl dut (
    .clk             (clk),
    .resetn          (resetn),
    .write_data      (write_data),
    .channel         (channel),
    .data_in         (data_in),
    .buf_ack         (buf_ack),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .buffer_selector (buffer_selector),
    .irq             (irq),
    .overrun         (overrun),
    .sync_err        (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [15:0] data;
    bit          irq;
    int          due;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int writes_seen = 0;
  int irqs_seen = 0;
  int last_write_addr = -1;
  int last_irq_addr = -1;

  // reference model state
  bit m_fill;
  int m_exp;
  int m_wbank;
  int m_sidx;
  bit m_pending;
  bit m_sel;
  bit m_overrun;
  bit m_sync_err;

  task automatic model_reset();
    m_fill = 0; m_exp = 0; m_wbank = 0; m_sidx = 0;
    m_pending = 0; m_sel = 0; m_overrun = 0; m_sync_err = 0;
    sb.delete();
  endtask

  task automatic model_accept(input int ch, input logic [15:0] d, input bit ack_w);
    bit wr = 0;
    bit cmp;
    exp_t e;
`ifdef MIC_BUFFER_SYNC_CHECK_EN
    if (!m_fill) begin
      if (ch == 0) wr = 1;
    end else if (ch == m_exp) begin
      wr = 1;
    end else begin
      m_sync_err = 1; m_fill = 0; m_sidx = 0; m_exp = 0;
    end
`else
    wr = 1;
`endif
    if (wr) begin
      m_fill = 1;
      cmp = (ch == CH - 1) && (m_sidx == FS - 1);
      e.addr = m_wbank * BANK + m_sidx * CH + ch;
      e.data = d;
      e.irq  = cmp;
      e.due  = cyc + 1;
      sb.push_back(e);
      if (ch == CH - 1) m_sidx = cmp ? 0 : m_sidx + 1;
      m_exp = (ch == CH - 1) ? 0 : ch + 1;
      if (cmp) begin
        if (m_pending) m_overrun = 1;
        m_pending = 1;
        m_sel = m_wbank[0];
        m_wbank = 1 - m_wbank;
      end
    end
    if (ack_w) m_pending = 0;
  endtask

  // Monitor: every memory write must match the head of the expectation queue.
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #2;
    if (mem_we === 1'b1) begin
      writes_seen++;
      last_write_addr = int'(mem_addr);
      if (irq === 1'b1) begin
        irqs_seen++;
        last_irq_addr = int'(mem_addr);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, want no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        checks++;
        if (cyc !== e.due) begin
          errors++;
          $display("FAIL write_latency: got cycle %0d, want %0d", cyc, e.due);
        end
        checks++;
        if (int'(mem_addr) !== e.addr) begin
          errors++;
          $display("FAIL write_addr: got %0d, want %0d", mem_addr, e.addr);
        end
        checks++;
        if (mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write_data: got %h, want %h (addr %0d)", mem_wdata, e.data, e.addr);
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL write_irq: got %b, want %b (addr %0d)", irq, e.irq, e.addr);
        end
      end
    end else begin
      if (irq === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL irq_without_write: got irq=1, want 0");
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_write: got none, want addr=%0d due cycle %0d", sb[0].addr, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b1; write_data = 1'b0; buf_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic send(input int ch, input logic [15:0] d, input bit ack_w);
    @(negedge clk);
    buf_ack = 1'b0;
    write_data = 1'b1;
    channel = 3'(ch);
    data_in = d;
    model_accept(ch, d, ack_w);
    @(negedge clk);
    write_data = 1'b0;
    buf_ack = ack_w;
  endtask

  task automatic send_seq(input int start_ch, input int n, input bit ack_last);
    for (int k = 0; k < n; k++) begin
      send((start_ch + k) % CH, 16'($urandom_range(0, 65535)), ack_last && (k == n - 1));
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    buf_ack = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 13'd0) begin errors++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    checks++; if (mem_wdata !== 16'd0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (buffer_selector !== 1'b0) begin errors++; $display("FAIL rst_sel: got %b want 0", buffer_selector); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_sync_err: got %b want 0", sync_err); end
  endtask

  task automatic test_first_row();
    int w0;
    do_reset();
    w0 = writes_seen;
    for (int c = 0; c < CH; c++) send(c, 16'h0100 + 16'(c), 1'b0);
    idle(2);
    checks++;
    if (writes_seen - w0 !== CH) begin
      errors++; $display("FAIL first_row_writes: got %0d want %0d", writes_seen - w0, CH);
    end
  endtask

  task automatic test_full_bank();
    int i0;
    do_reset();
    i0 = irqs_seen;
    send_seq(0, BANK, 1'b0);
    idle(2);
    checks++; if (irqs_seen - i0 !== 1) begin errors++; $display("FAIL bank1_irqs: got %0d want 1", irqs_seen - i0); end
    checks++; if (last_irq_addr !== BANK - 1) begin errors++; $display("FAIL bank1_irq_addr: got %0d want %0d", last_irq_addr, BANK - 1); end
    checks++; if (buffer_selector !== 1'b0) begin errors++; $display("FAIL bank1_sel: got %b want 0", buffer_selector); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bank1_overrun: got %b want 0", overrun); end
    send(0, 16'h1234, 1'b0);
    idle(2);
    checks++; if (last_write_addr !== BANK) begin errors++; $display("FAIL bank2_first_addr: got %0d want %0d", last_write_addr, BANK); end
  endtask

  task automatic test_overrun();
    send_seq(1, BANK - 1, 1'b0);
    idle(2);
    checks++; if (overrun !== m_overrun || overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    checks++; if (buffer_selector !== m_sel || buffer_selector !== 1'b1) begin errors++; $display("FAIL bank2_sel: got %b want 1", buffer_selector); end
    send(0, 16'h4321, 1'b0);
    idle(2);
    checks++; if (last_write_addr !== 0) begin errors++; $display("FAIL bank3_first_addr: got %0d want 0", last_write_addr); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_ack_coincident();
    do_reset();
    send_seq(0, BANK, 1'b1);
    idle(2);
    send_seq(0, BANK, 1'b0);
    idle(2);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ack_overrun: got %b want 0", overrun); end
    checks++; if (buffer_selector !== 1'b1) begin errors++; $display("FAIL ack_sel: got %b want 1", buffer_selector); end
  endtask

  task automatic test_held_high();
    int w0;
    do_reset();
    w0 = writes_seen;
    @(negedge clk);
    write_data = 1'b1; channel = 3'd0; data_in = 16'h0ABC;
    model_accept(0, 16'h0ABC, 1'b0);
    repeat (10) @(negedge clk);
    write_data = 1'b0;
    idle(2);
    checks++;
    if (writes_seen - w0 !== 1) begin
      errors++; $display("FAIL held_high_writes: got %0d want 1", writes_seen - w0);
    end
  endtask

  task automatic test_reset_mid();
    int i0;
    do_reset();
    send_seq(0, 100 * CH + 3, 1'b0);
    i0 = irqs_seen;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    resetn = 1'b0;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b want 0", mem_we); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b want 0", irq); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we_after: got %b want 0", mem_we); end
    send(0, 16'h5A5A, 1'b0);
    idle(2);
    checks++; if (last_write_addr !== 0) begin errors++; $display("FAIL midrst_addr: got %0d want 0", last_write_addr); end
    send(1, 16'h5A5B, 1'b0);
    idle(2);
    checks++; if (last_write_addr !== 1) begin errors++; $display("FAIL midrst_addr1: got %0d want 1", last_write_addr); end
    checks++; if (irqs_seen !== i0) begin errors++; $display("FAIL midrst_irqs: got %0d want %0d", irqs_seen, i0); end
  endtask

`ifdef MIC_BUFFER_SYNC_CHECK_EN
  task automatic test_sync();
    int w0;
    do_reset();
    w0 = writes_seen;
    send(3, 16'h0303, 1'b0);
    send(0, 16'h0300, 1'b0);
    send(1, 16'h0301, 1'b0);
    send(5, 16'h0305, 1'b0);
    idle(2);
    checks++; if (writes_seen - w0 !== 2) begin errors++; $display("FAIL sync_writes: got %0d want 2", writes_seen - w0); end
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_err_set: got %b want 1", sync_err); end
    send(1, 16'h0311, 1'b0);
    send(0, 16'h0310, 1'b0);
    idle(2);
    checks++; if (writes_seen - w0 !== 3) begin errors++; $display("FAIL sync_idle_writes: got %0d want 3", writes_seen - w0); end
    checks++; if (last_write_addr !== 0) begin errors++; $display("FAIL sync_realign_addr: got %0d want 0", last_write_addr); end
  endtask
`else
  task automatic test_unaligned();
    do_reset();
    send(3, 16'h0303, 1'b0);
    send(0, 16'h0300, 1'b0);
    send(5, 16'h0305, 1'b0);
    send(7, 16'h0307, 1'b0);
    send(2, 16'h0312, 1'b0);
    idle(2);
    checks++; if (last_write_addr !== CH + 2) begin errors++; $display("FAIL unaligned_addr: got %0d want %0d", last_write_addr, CH + 2); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_err_tied: got %b want 0", sync_err); end
  endtask
`endif

  initial begin
    resetn = 1'b1; write_data = 1'b0; channel = '0; data_in = '0; buf_ack = 1'b0;
    model_reset();
    test_reset();
    test_first_row();
    test_full_bank();
    test_overrun();
    test_ack_coincident();
    test_held_high();
    test_reset_mid();
`ifdef MIC_BUFFER_SYNC_CHECK_EN
    test_sync();
`else
    test_unaligned();
`endif
    idle(3);
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL queue_drained: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
